// File: rtl/eh2_bp_pkg.sv
// eh2_bp_pkg: shared types, constants and the 2-bit counter update for the BHT update path
package eh2_bp_pkg;
    localparam int BHT_IDX_W = 8;
    localparam logic [1:0] BHT_CTR_SNT = 2'b00;
    localparam logic [1:0] BHT_CTR_STK = 2'b11;

    typedef struct packed {
        logic [BHT_IDX_W-1:0] idx;
        logic [1:0]           ctr;
    } bht_upd_pkt_t;

    typedef enum logic {INIT, RUN} bht_arb_state_e;

    function automatic logic [1:0] bht_ctr_next(logic [1:0] ctr, logic taken);
        return taken ? ((ctr == BHT_CTR_STK) ? ctr : ctr + 2'd1)
                     : ((ctr == BHT_CTR_SNT) ? ctr : ctr - 2'd1);
    endfunction
endpackage

// File: rtl/eh2_bht_upd_fifo.sv
// eh2_bht_upd_fifo: per-thread update queue with wrapping pointers and an occupancy count
module eh2_bht_upd_fifo #(
    parameter int QDEPTH = 2,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(QDEPTH);
    logic [W-1:0]  r_mem [QDEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0]   r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + {{(PW-1){1'b0}}, push};
            r_rp  <= r_rp + {{(PW-1){1'b0}}, pop};
            r_cnt <= r_cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // Storage needs no reset: the cleared count masks stale contents
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wp] <= din;
    end

    assign dout  = r_mem[r_rp];
    assign empty = r_cnt == '0;
    assign full  = r_cnt == (PW+1)'(QDEPTH);
endmodule

// File: rtl/eh2_bht_update_arb.sv
// eh2_bht_update_arb: queues per-thread BHT updates, round-robins them onto the single
// BHT write port, and runs the clear sweep after reset or a predictor flush.
module eh2_bht_update_arb
    import eh2_bp_pkg::*;
#(
    parameter int BHT_ADDR_WIDTH = 8,
    parameter int QDEPTH         = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     upd_valid,
    output logic [1:0]                     upd_ready,
    input  logic [1:0][BHT_ADDR_WIDTH-1:0] upd_index,
    input  logic [1:0][BHT_ADDR_WIDTH-1:0] upd_ghr,
    input  logic [1:0][1:0]                upd_ctr,
    input  logic [1:0]                     upd_taken,
    input  logic                           bp_flush,
    output logic                           wr_en,
    output logic [BHT_ADDR_WIDTH-1:0]      wr_addr,
    output logic [1:0]                     wr_data,
    output logic                           init_done,
    output logic                           busy
);
    localparam int NUM_THREADS = 2;
    localparam int PW          = BHT_ADDR_WIDTH + 2;

    bht_arb_state_e                   r_state;
    logic [BHT_ADDR_WIDTH-1:0]        r_sweep, r_wr_addr;
    logic [1:0]                       r_wr_data;
    logic                             r_wr_en, r_init_done, r_rr;
    logic [NUM_THREADS-1:0]           w_push, w_pop, w_empty, w_full;
    logic [NUM_THREADS-1:0][PW-1:0]   w_din, w_dout;
    logic                             w_run, w_both, w_any, w_sel;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_q
        assign w_din[t]  = {upd_index[t] ^ upd_ghr[t], bht_ctr_next(upd_ctr[t], upd_taken[t])};
        assign w_push[t] = upd_valid[t] & ~w_full[t];
        assign w_pop[t]  = w_any & (w_sel == 1'(t));
        eh2_bht_upd_fifo #(.QDEPTH(QDEPTH), .W(PW)) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .flush(bp_flush),
            .push (w_push[t]),
            .pop  (w_pop[t]),
            .din  (w_din[t]),
            .dout (w_dout[t]),
            .empty(w_empty[t]),
            .full (w_full[t])
        );
    end

    assign w_run  = (r_state == RUN) & ~bp_flush;
    assign w_both = ~w_empty[0] & ~w_empty[1];
    assign w_any  = w_run & ~&w_empty;
    assign w_sel  = w_both ? r_rr : w_empty[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_sweep     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= BHT_CTR_SNT;
            r_init_done <= 1'b0;
            r_rr        <= 1'b0;
        end else if (bp_flush) begin
            r_state     <= INIT;
            r_sweep     <= '0;
            r_wr_en     <= 1'b0;
            r_init_done <= 1'b0;
        end else if (r_state == INIT) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_sweep;
            r_wr_data <= BHT_CTR_SNT;
            r_sweep   <= r_sweep + 1'b1;
            if (&r_sweep) begin
                r_state     <= RUN;
                r_init_done <= 1'b1;
            end
        end else begin
            r_wr_en <= w_any;
            if (w_any) begin
                r_wr_addr <= w_dout[w_sel][PW-1:2];
                r_wr_data <= w_dout[w_sel][1:0];
            end
            // Pointer only moves when both threads actually compete
            if (w_both) r_rr <= ~r_rr;
        end
    end

    assign upd_ready = ~w_full;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign init_done = r_init_done;
    assign busy      = (r_state == INIT) | ~&w_empty | r_wr_en;
endmodule

// File: tb/tb_eh2_bht_update_arb.sv
// tb_eh2_bht_update_arb: directed vectors, corner sequences and random traffic
// compared against a queue-based reference model of the update arbiter.
module tb_eh2_bht_update_arb;
    localparam int QD = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      upd_valid = '0;
    logic [1:0]      upd_ready;
    logic [1:0][7:0] upd_index = '0;
    logic [1:0][7:0] upd_ghr = '0;
    logic [1:0][1:0] upd_ctr = '0;
    logic [1:0]      upd_taken = '0;
    logic            bp_flush = 1'b0;
    logic            wr_en;
    logic [7:0]      wr_addr;
    logic [1:0]      wr_data;
    logic            init_done;
    logic            busy;

    eh2_bht_update_arb dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_index(upd_index), .upd_ghr(upd_ghr), .upd_ctr(upd_ctr),
        .upd_taken(upd_taken), .bp_flush(bp_flush), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] mq0[$];
    logic [9:0] mq1[$];
    bit         m_run, m_done, m_rr;
    int         m_sweep;
    logic [7:0] wlog[$];

    typedef struct {
        logic [7:0] idx;
        logic [7:0] ghr;
        logic [1:0] ctr;
        logic       tk;
        logic [7:0] ea;
        logic [1:0] ed;
    } vec_t;
    vec_t tv[6];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] nxt(logic [1:0] c, logic tk);
        int v;
        v = int'(c) + (tk ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    task automatic m_reset();
        mq0.delete();
        mq1.delete();
        m_run = 0; m_done = 0; m_rr = 0; m_sweep = 0;
    endtask

    task automatic idle_in();
        upd_valid = '0; bp_flush = 1'b0;
    endtask

    // One clock: predict the edge from the model, advance, compare outputs
    task automatic cyc();
        bit         r0, r1, e_en;
        int         g;
        logic [9:0] p;
        logic [7:0] e_addr;
        logic [1:0] e_data;
        r0 = mq0.size() < QD;
        r1 = mq1.size() < QD;
        chk("upd_ready", 32'(upd_ready), 32'({r1, r0}));
        g = -1; e_en = 0; e_addr = '0; e_data = '0;
        if (m_run && !bp_flush) begin
            if (mq0.size() > 0 && mq1.size() > 0) begin g = int'(m_rr); m_rr = !m_rr; end
            else if (mq0.size() > 0) g = 0;
            else if (mq1.size() > 0) g = 1;
        end
        if (g == 0) p = mq0.pop_front();
        if (g == 1) p = mq1.pop_front();
        if (g >= 0) begin e_en = 1; e_addr = p[9:2]; e_data = p[1:0]; end
        if (upd_valid[0] && r0) mq0.push_back({upd_index[0] ^ upd_ghr[0], nxt(upd_ctr[0], upd_taken[0])});
        if (upd_valid[1] && r1) mq1.push_back({upd_index[1] ^ upd_ghr[1], nxt(upd_ctr[1], upd_taken[1])});
        if (bp_flush) begin
            mq0.delete(); mq1.delete();
            m_run = 0; m_done = 0; m_sweep = 0; e_en = 0;
        end else if (!m_run) begin
            e_en = 1; e_addr = 8'(m_sweep); e_data = 2'b00;
            m_sweep++;
            if (m_sweep == 256) begin m_run = 1; m_done = 1; end
        end
        @(posedge clk); #1;
        chk("wr_en", 32'(wr_en), 32'(e_en));
        if (e_en) begin
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
            wlog.push_back(wr_addr);
        end
        chk("init_done", 32'(init_done), 32'(m_done));
        chk("busy", 32'(busy), 32'(!m_run || mq0.size() > 0 || mq1.size() > 0 || e_en));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        #1;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_upd_ready", 32'(upd_ready), 3);
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic run_to_done();
        int k;
        k = 0;
        while (!init_done && k < 300) begin cyc(); k++; end
        chk("init_timeout", 32'(init_done), 1);
    endtask

    initial begin
        tv[0] = '{8'h12, 8'h03, 2'b01, 1'b1, 8'h11, 2'b10};
        tv[1] = '{8'h34, 8'h34, 2'b11, 1'b1, 8'h00, 2'b11};
        tv[2] = '{8'hA5, 8'h0F, 2'b00, 1'b0, 8'hAA, 2'b00};
        tv[3] = '{8'hFF, 8'h00, 2'b10, 1'b0, 8'hFF, 2'b01};
        tv[4] = '{8'h00, 8'hC3, 2'b01, 1'b0, 8'hC3, 2'b00};
        tv[5] = '{8'h5A, 8'hA5, 2'b10, 1'b1, 8'hFF, 2'b11};

        @(posedge clk); #1;
        do_reset();

        for (int i = 0; i < 256; i++) begin
            cyc();
            chk("sweep_addr", 32'(wr_addr), 32'(i));
            chk("sweep_done", 32'(init_done), 32'(i == 255));
        end
        cyc();
        chk("busy_after_init", 32'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            upd_valid = 2'b01;
            upd_index[0] = tv[i].idx; upd_ghr[0] = tv[i].ghr;
            upd_ctr[0] = tv[i].ctr; upd_taken[0] = tv[i].tk;
            cyc();
            idle_in();
            cyc();
            chk("vec_wr_en", 32'(wr_en), 1);
            chk("vec_addr", 32'(wr_addr), 32'(tv[i].ea));
            chk("vec_data", 32'(wr_data), 32'(tv[i].ed));
            cyc();
        end

        wlog.delete();
        upd_ghr = '0; upd_ctr = '0; upd_taken = 2'b11;
        upd_valid = 2'b11; upd_index[0] = 8'h01; upd_index[1] = 8'h81;
        cyc();
        upd_index[0] = 8'h02; upd_index[1] = 8'h82;
        cyc();
        idle_in();
        for (int i = 0; i < 6; i++) cyc();
        chk("rr_count", 32'(wlog.size()), 4);
        if (wlog.size() == 4) begin
            chk("rr_w0", 32'(wlog[0]), 32'h01);
            chk("rr_w1", 32'(wlog[1]), 32'h81);
            chk("rr_w2", 32'(wlog[2]), 32'h02);
            chk("rr_w3", 32'(wlog[3]), 32'h82);
        end

        do_reset();
        upd_valid = 2'b01; upd_ghr = '0;
        for (int k = 0; k < 10; k++) begin
            upd_index[0] = 8'(k);
            cyc();
            if (k >= 1) chk("bp_ready0", 32'(upd_ready[0]), 0);
        end
        idle_in();
        run_to_done();
        wlog.delete();
        for (int i = 0; i < 10; i++) cyc();
        chk("bp_writes", 32'(wlog.size()), 2);
        if (wlog.size() == 2) begin
            chk("bp_w0", 32'(wlog[0]), 0);
            chk("bp_w1", 32'(wlog[1]), 1);
        end

        do_reset();
        for (int i = 0; i < 10; i++) cyc();
        upd_valid = 2'b10; upd_index[1] = 8'h77; upd_ghr[1] = 8'h00;
        upd_ctr[1] = 2'b01; upd_taken[1] = 1'b1;
        cyc();
        idle_in();
        begin
            int k;
            k = 0;
            while (wr_addr != 8'h3F && k < 300) begin cyc(); k++; end
            chk("flush_reach", 32'(wr_addr), 32'h3F);
        end
        bp_flush = 1'b1;
        cyc();
        bp_flush = 1'b0;
        chk("flush_wr_en", 32'(wr_en), 0);
        cyc();
        chk("flush_restart", 32'(wr_addr), 0);
        chk("flush_done", 32'(init_done), 0);
        run_to_done();
        wlog.delete();
        for (int i = 0; i < 10; i++) cyc();
        chk("flush_no_write", 32'(wlog.size()), 0);

        for (int i = 0; i < 3000; i++) begin
            upd_valid = 2'($urandom_range(0, 3));
            for (int t = 0; t < 2; t++) begin
                upd_index[t] = 8'($urandom);
                upd_ghr[t]   = 8'($urandom);
                upd_ctr[t]   = 2'($urandom);
                upd_taken[t] = 1'($urandom);
            end
            bp_flush = ($urandom_range(0, 399) == 0);
            cyc();
        end
        upd_valid = 2'b11;
        cyc();
        do_reset();
        for (int i = 0; i < 20; i++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
